// File: rtl/cpu_pkg.sv
// Shared types and ALU function for the CPU execute/writeback stage.
// Signed 8-bit datapath over an 8-entry register file.
package cpu_pkg;

   localparam int NUMBER_OF_REGISTERS = 8;
   localparam int REG_AW = $clog2(NUMBER_OF_REGISTERS);
   localparam int DATA_WIDTH = 8;

   typedef logic signed [DATA_WIDTH-1:0] data_t;

   typedef enum logic [3:0] {
      OP_NOP = 4'd0,
      OP_ADD = 4'd1,
      OP_SUB = 4'd2,
      OP_AND = 4'd3,
      OP_OR  = 4'd4,
      OP_XOR = 4'd5,
      OP_SLL = 4'd6,
      OP_SRA = 4'd7,
      OP_MUL = 4'd8,
      OP_MOV = 4'd9
   } opcode_t;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      MUL_BUSY,
      WB
   } ex_state_t;

   typedef struct packed {
      data_t result;
      logic  ovf;
   } alu_out_t;

   function automatic alu_out_t alu_compute(
      opcode_t op,
      data_t   a,
      data_t   b
   );
      alu_out_t r;
      r.result = '0;
      r.ovf    = 1'b0;
      case (op)
         OP_ADD: begin
            r.result = a + b;
            r.ovf = (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) &&
                    (r.result[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
         end
         OP_SUB: begin
            r.result = a - b;
            r.ovf = (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) &&
                    (r.result[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
         end
         OP_AND: r.result = a & b;
         OP_OR:  r.result = a | b;
         OP_XOR: r.result = a ^ b;
         OP_SLL: r.result = a << b[2:0];
         OP_SRA: r.result = a >>> b[2:0];
         OP_MOV: r.result = b;
         default: ;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/cpu_serial_multiplier.sv
// Unsigned 8x8 shift-add multiplier, one partial product per cycle.
// done/product are valid combinationally during the eighth step.
module cpu_serial_multiplier
   import cpu_pkg::*;
(
   input  logic                    clock_in,
   input  logic                    reset_in,
   input  logic                    start,
   input  logic [DATA_WIDTH-1:0]   a,
   input  logic [DATA_WIDTH-1:0]   b,
   output logic                    done,
   output logic [2*DATA_WIDTH-1:0] product
);

   logic [2*DATA_WIDTH-1:0] mcand;
   logic [2*DATA_WIDTH-1:0] acc;
   logic [2*DATA_WIDTH-1:0] acc_nxt;
   logic [DATA_WIDTH-1:0]   mplier;
   logic [2:0]              cnt;
   logic                    busy;

   assign acc_nxt = acc + (mplier[0] ? mcand : '0);
   assign done    = busy && (cnt == 3'd7);
   assign product = acc_nxt;

   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         mcand  <= '0;
         acc    <= '0;
         mplier <= '0;
         cnt    <= '0;
         busy   <= 1'b0;
      end else if (start) begin
         mcand  <= {{DATA_WIDTH{1'b0}}, a};
         acc    <= '0;
         mplier <= b;
         cnt    <= '0;
         busy   <= 1'b1;
      end else if (busy) begin
         acc    <= acc_nxt;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + 3'd1;
         if (cnt == 3'd7)
            busy <= 1'b0;
      end
   end

endmodule

// File: rtl/cpu_execute_writeback.sv
// Single-issue execute + writeback stage driving the register file ports.
// One instruction in flight; write port outputs are registered.
module cpu_execute_writeback
   import cpu_pkg::*;
(
   input  logic              clock_in,
   input  logic              reset_in,
   input  logic              instr_valid_in,
   output logic              instr_ready_out,
   input  logic [3:0]        opcode_in,
   input  logic [REG_AW-1:0] rd_in,
   input  logic [REG_AW-1:0] rs1_in,
   input  logic [REG_AW-1:0] rs2_in,
   input  logic signed [DATA_WIDTH-1:0] imm_in,
   input  logic              use_imm_in,
   output logic [REG_AW-1:0] read_register_address1_out,
   output logic [REG_AW-1:0] read_register_address2_out,
   input  logic signed [DATA_WIDTH-1:0] read_data1_in,
   input  logic signed [DATA_WIDTH-1:0] read_data2_in,
   output logic              write_enable_out,
   output logic [REG_AW-1:0] write_register_address_out,
   output logic signed [DATA_WIDTH-1:0] write_data_out,
   input  logic              clear_flags_in,
   output logic              overflow_out,
   output logic              illegal_op_out
);

   ex_state_t         state, state_nxt;
   opcode_t           op_q;
   logic [REG_AW-1:0] rd_q, rs1_q, rs2_q;
   data_t             imm_q;
   logic              use_imm_q;
   logic              sign_q;

   data_t                   op_a, op_b;
   alu_out_t                alu;
   logic [DATA_WIDTH-1:0]   mag_a, mag_b;
   logic                    is_mul, is_nop, is_ill, is_alu;
   logic                    mul_start, mul_done;
   logic [2*DATA_WIDTH-1:0] product, p_signed;
   data_t                   mul_res;
   logic                    mul_ovf;
   logic                    wr_set, ovf_set, ill_set;

   assign op_a  = read_data1_in;
   assign op_b  = use_imm_q ? imm_q : read_data2_in;
   assign alu   = alu_compute(op_q, op_a, op_b);
   assign mag_a = op_a[DATA_WIDTH-1] ? -op_a : op_a;
   assign mag_b = op_b[DATA_WIDTH-1] ? -op_b : op_b;

   assign is_mul = (op_q == OP_MUL);
   assign is_nop = (op_q == OP_NOP);
   assign is_ill = (op_q > OP_MOV);
   assign is_alu = !is_mul && !is_nop && !is_ill;

   assign mul_start = (state == EXEC) && is_mul;

   cpu_serial_multiplier u_mul (
      .clock_in (clock_in),
      .reset_in (reset_in),
      .start    (mul_start),
      .a        (mag_a),
      .b        (mag_b),
      .done     (mul_done),
      .product  (product)
   );

   // |A|*|B| fits in 15 bits, so the negated product never wraps in 16
   assign p_signed = sign_q ? ('0 - product) : product;
   assign mul_res  = p_signed[DATA_WIDTH-1:0];
   assign mul_ovf  = p_signed !=
      {{DATA_WIDTH{p_signed[DATA_WIDTH-1]}}, p_signed[DATA_WIDTH-1:0]};

   assign wr_set  = ((state == EXEC) && is_alu) ||
                    ((state == MUL_BUSY) && mul_done);
   assign ovf_set = ((state == EXEC) && is_alu && alu.ovf) ||
                    ((state == MUL_BUSY) && mul_done && mul_ovf);
   assign ill_set = (state == EXEC) && is_ill;

   assign instr_ready_out            = (state == IDLE);
   assign read_register_address1_out = rs1_q;
   assign read_register_address2_out = rs2_q;

   always_ff @(posedge clock_in) begin
      if (reset_in) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:     if (instr_valid_in) state_nxt = EXEC;
         EXEC: begin
            if (is_mul)               state_nxt = MUL_BUSY;
            else if (is_nop || is_ill) state_nxt = IDLE;
            else                      state_nxt = WB;
         end
         MUL_BUSY: if (mul_done) state_nxt = WB;
         WB:       state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         op_q                       <= OP_NOP;
         rd_q                       <= '0;
         rs1_q                      <= '0;
         rs2_q                      <= '0;
         imm_q                      <= '0;
         use_imm_q                  <= 1'b0;
         sign_q                     <= 1'b0;
         write_enable_out           <= 1'b0;
         write_register_address_out <= '0;
         write_data_out             <= '0;
         overflow_out               <= 1'b0;
         illegal_op_out             <= 1'b0;
      end else begin
         if (state == IDLE && instr_valid_in) begin
            op_q      <= opcode_t'(opcode_in);
            rd_q      <= rd_in;
            rs1_q     <= rs1_in;
            rs2_q     <= rs2_in;
            imm_q     <= imm_in;
            use_imm_q <= use_imm_in;
         end
         if (mul_start)
            sign_q <= op_a[DATA_WIDTH-1] ^ op_b[DATA_WIDTH-1];
         write_enable_out <= wr_set && (rd_q != '0);
         if (wr_set) begin
            write_register_address_out <= rd_q;
            write_data_out <= (state == EXEC) ? alu.result : mul_res;
         end
         // a flag event in the same cycle as a clear keeps the flag set
         if (ovf_set)             overflow_out <= 1'b1;
         else if (clear_flags_in) overflow_out <= 1'b0;
         if (ill_set)             illegal_op_out <= 1'b1;
         else if (clear_flags_in) illegal_op_out <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cpu_execute_writeback.sv
// Directed bench for cpu_execute_writeback with a register-file model.
// Timing indices count negedges after the accepting clock edge.
module tb_cpu_execute_writeback;

   localparam int NOP = 0, ADD = 1, SLL = 6, SRA = 7, MUL = 8, MOV = 9;

   logic       clock_in = 1'b0;
   logic       reset_in;
   logic       instr_valid_in;
   logic       instr_ready_out;
   logic [3:0] opcode_in;
   logic [2:0] rd_in, rs1_in, rs2_in;
   logic signed [7:0] imm_in;
   logic       use_imm_in;
   logic [2:0] raddr1, raddr2;
   logic signed [7:0] rdata1, rdata2;
   logic       we;
   logic [2:0] waddr;
   logic signed [7:0] wdata;
   logic       clear_flags_in;
   logic       overflow_out, illegal_op_out;

   logic [7:0] rf [8] = '{default: 8'h00};

   int nerr = 0;
   int nchk = 0;
   int we_at, n_we, rdy_at, acc;

   always #5 clock_in = ~clock_in;

   always @(posedge clock_in)
      if (we) rf[waddr] <= wdata;

   assign rdata1 = rf[raddr1];
   assign rdata2 = rf[raddr2];

   cpu_execute_writeback dut (
      .clock_in                   (clock_in),
      .reset_in                   (reset_in),
      .instr_valid_in             (instr_valid_in),
      .instr_ready_out            (instr_ready_out),
      .opcode_in                  (opcode_in),
      .rd_in                      (rd_in),
      .rs1_in                     (rs1_in),
      .rs2_in                     (rs2_in),
      .imm_in                     (imm_in),
      .use_imm_in                 (use_imm_in),
      .read_register_address1_out (raddr1),
      .read_register_address2_out (raddr2),
      .read_data1_in              (rdata1),
      .read_data2_in              (rdata2),
      .write_enable_out           (we),
      .write_register_address_out (waddr),
      .write_data_out             (wdata),
      .clear_flags_in             (clear_flags_in),
      .overflow_out               (overflow_out),
      .illegal_op_out             (illegal_op_out)
   );

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic set_instr(input int op, input int rd, input int rs1,
                            input int rs2, input int imm, input bit ui);
      opcode_in  = 4'(op);
      rd_in      = 3'(rd);
      rs1_in     = 3'(rs1);
      rs2_in     = 3'(rs2);
      imm_in     = 8'(imm);
      use_imm_in = ui;
   endtask

   task automatic wait_ready();
      int w = 0;
      while (!instr_ready_out && w < 40) begin
         @(negedge clock_in);
         w++;
      end
      if (!instr_ready_out) check_eq("ready_wait", instr_ready_out, 1);
   endtask

   // called at a negedge; returns at a negedge 15 cycles after acceptance
   task automatic issue(input int op, input int rd, input int rs1,
                        input int rs2, input int imm, input bit ui);
      set_instr(op, rd, rs1, rs2, imm, ui);
      instr_valid_in = 1'b1;
      wait_ready();
      @(posedge clock_in);
      #1 instr_valid_in = 1'b0;
      we_at = -1; n_we = 0; rdy_at = -1;
      for (int k = 0; k < 15; k++) begin
         @(negedge clock_in);
         if (we) begin
            n_we++;
            if (we_at < 0) we_at = k;
         end
         if (instr_ready_out && rdy_at < 0) rdy_at = k;
      end
   endtask

   task automatic pulse_clear();
      clear_flags_in = 1'b1;
      @(negedge clock_in);
      clear_flags_in = 1'b0;
      @(negedge clock_in);
   endtask

   initial begin
      reset_in = 1'b1;
      instr_valid_in = 1'b0;
      clear_flags_in = 1'b0;
      set_instr(NOP, 0, 0, 0, 0, 1'b0);
      repeat (3) @(negedge clock_in);
      reset_in = 1'b0;
      check_eq("rst_ready", instr_ready_out, 1);
      check_eq("rst_we", we, 0);
      check_eq("rst_waddr", waddr, 0);
      check_eq("rst_wdata", wdata, 0);
      check_eq("rst_flags", {overflow_out, illegal_op_out}, 0);
      check_eq("rst_raddr", {raddr1, raddr2}, 0);

      issue(MOV, 1, 0, 0, 5, 1'b1);
      check_eq("mov_r1", rf[1], 8'h05);
      issue(MOV, 2, 0, 0, -3, 1'b1);
      check_eq("mov_r2", rf[2], 8'hFD);
      issue(ADD, 3, 1, 2, 0, 1'b0);
      check_eq("add_r3", rf[3], 8'h02);
      check_eq("add_we_at", we_at, 1);
      check_eq("add_n_we", n_we, 1);
      check_eq("add_rdy_at", rdy_at, 2);
      check_eq("add_ovf", overflow_out, 0);

      issue(MOV, 1, 0, 0, 100, 1'b1);
      issue(MOV, 2, 0, 0, 100, 1'b1);
      issue(ADD, 4, 1, 2, 0, 1'b0);
      check_eq("add_ovf_r4", rf[4], 8'hC8);
      check_eq("add_ovf_set", overflow_out, 1);
      issue(ADD, 3, 3, 3, 0, 1'b0);
      check_eq("ovf_sticky", overflow_out, 1);
      check_eq("add_r3_dbl", rf[3], 8'h04);
      pulse_clear();
      check_eq("ovf_cleared", overflow_out, 0);

      issue(MOV, 1, 0, 0, -7, 1'b1);
      issue(MOV, 2, 0, 0, 9, 1'b1);
      issue(MUL, 5, 1, 2, 0, 1'b0);
      check_eq("mul_r5", rf[5], 8'hC1);
      check_eq("mul_we_at", we_at, 9);
      check_eq("mul_n_we", n_we, 1);
      check_eq("mul_rdy_at", rdy_at, 10);
      check_eq("mul_ovf0", overflow_out, 0);
      issue(MOV, 1, 0, 0, 20, 1'b1);
      issue(MUL, 5, 1, 0, 20, 1'b1);
      check_eq("mul_big_r5", rf[5], 8'h90);
      check_eq("mul_big_ovf", overflow_out, 1);
      pulse_clear();

      issue(MOV, 1, 0, 0, -128, 1'b1);
      issue(SRA, 6, 1, 0, 3, 1'b1);
      check_eq("sra_r6", rf[6], 8'hF0);
      issue(MOV, 1, 0, 0, 1, 1'b1);
      issue(SLL, 7, 1, 0, 7, 1'b1);
      check_eq("sll_r7", rf[7], 8'h80);
      issue(ADD, 0, 1, 1, 0, 1'b0);
      check_eq("rd0_n_we", n_we, 0);
      check_eq("rd0_rdy_at", rdy_at, 2);

      issue(12, 3, 1, 1, 0, 1'b0);
      check_eq("ill_flag", illegal_op_out, 1);
      check_eq("ill_n_we", n_we, 0);
      check_eq("ill_rdy_at", rdy_at, 1);
      check_eq("ill_r3", rf[3], 8'h04);

      issue(MOV, 1, 0, 0, -7, 1'b1);
      set_instr(MUL, 5, 1, 0, 9, 1'b1);
      instr_valid_in = 1'b1;
      acc = 0;
      for (int i = 0; i < 11; i++) begin
         if (instr_ready_out) acc++;
         @(negedge clock_in);
      end
      instr_valid_in = 1'b0;
      repeat (3) @(negedge clock_in);
      check_eq("held_accepts", acc, 1);
      check_eq("held_r5", rf[5], 8'hC1);

      set_instr(MUL, 5, 1, 0, 20, 1'b1);
      instr_valid_in = 1'b1;
      wait_ready();
      @(posedge clock_in);
      #1 instr_valid_in = 1'b0;
      repeat (6) @(negedge clock_in);
      check_eq("midmul_busy", instr_ready_out, 0);
      reset_in = 1'b1;
      @(negedge clock_in);
      reset_in = 1'b0;
      check_eq("midrst_ready", instr_ready_out, 1);
      check_eq("midrst_we", we, 0);
      check_eq("midrst_flags", {overflow_out, illegal_op_out}, 0);
      check_eq("midrst_wr", {waddr, wdata}, 0);
      check_eq("midrst_raddr", raddr1, 0);
      n_we = 0;
      for (int k = 0; k < 14; k++) begin
         @(negedge clock_in);
         if (we) n_we++;
      end
      check_eq("midrst_no_we", n_we, 0);
      check_eq("midrst_r5", rf[5], 8'hC1);
      check_eq("midrst_ovf", overflow_out, 0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
